// File: rtl/modulo_receptor_varredura_matriz_pkg.sv
`default_nettype none
// ============================================================================
// Module : modulo_receptor_varredura_matriz_pkg
// Brief  : Shared constants, FSM encoding and index helpers for the matrix
//          scan receiver.
// Rev    : 1.0 - initial release
// ============================================================================
package modulo_receptor_varredura_matriz_pkg;

  localparam int N_COL   = 5;
  localparam int N_LINE  = 7;
  localparam int FRAME_W = 35;

  typedef enum logic [1:0] {
    SYNC_WAIT  = 2'd0,
    COL_SETTLE = 2'd1,
    COL_DONE   = 2'd2
  } state_t;

  // Frame bit for a given line/column; column 0 lands on the high end of each line group.
  function automatic int bit_index(input int line, input int col);
    return N_COL * line + (N_COL - 1 - col);
  endfunction

  function automatic logic [2:0] col_index(input logic [N_COL-1:0] col_sel);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < N_COL; i++) begin
      if (col_sel[i]) idx = 3'(N_COL - 1 - i);
    end
    return idx;
  endfunction

  function automatic logic is_one_hot(input logic [N_COL-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/modulo_receptor_varredura_matriz_sincronizador.sv
`default_nettype none
// ============================================================================
// Module : modulo_sincronizador_2ff
// Brief  : Two-stage flip-flop synchroniser, parameterised width.
// Rev    : 1.0 - initial release
// ============================================================================
module modulo_sincronizador_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/modulo_receptor_varredura_matriz.sv
`default_nettype none
// ============================================================================
// Module : modulo_receptor_varredura_matriz
// Brief  : Receive end of the 5x7 LED matrix scan; rebuilds 35-bit frames and
//          delivers them over valid/ack. Optional MATRIZ_RX_CHANGE_ONLY_EN
//          drops frames identical to the last delivered one.
// Rev    : 1.0 - initial release
// ============================================================================
module modulo_receptor_varredura_matriz
  import modulo_receptor_varredura_matriz_pkg::*;
#(
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [N_COL-1:0]   m_col,
  input  logic [N_LINE-1:0]  m_line,
  input  logic               frame_ack,
  output logic [FRAME_W-1:0] frame_out,
  output logic               frame_valid,
  output logic               scan_err,
  output logic               scan_lost,
  output logic               overrun
);

  localparam logic [15:0] c_to_max  = 16'(TIMEOUT_CYC);
  localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYC - 1);
  localparam logic        c_settle_imm = (SETTLE_CYC <= 1);

  logic [N_COL-1:0]   w_col_s;
  logic [N_LINE-1:0]  w_line_s;

  modulo_sincronizador_2ff #(.WIDTH(N_COL)) u_sync_col (
    .clk(clk), .rst_n(clr), .d(m_col), .q(w_col_s)
  );

  modulo_sincronizador_2ff #(.WIDTH(N_LINE)) u_sync_line (
    .clk(clk), .rst_n(clr), .d(m_line), .q(w_line_s)
  );

  state_t             r_state;
  logic [2:0]         r_idx;
  logic [4:0]         r_settle;
  logic [FRAME_W-1:0] r_buf;
  logic               r_complete;
  logic [N_COL-1:0]   r_col_prev;
  logic [15:0]        r_to_cnt;
  logic [FRAME_W-1:0] r_frame_out;
  logic               r_frame_valid;
  logic               r_scan_err;
  logic               r_scan_lost;
  logic               r_overrun;

  logic               w_blank, w_valid, w_illegal, w_same, w_adv;
  logic               w_err, w_enter, w_latch, w_settled, w_new_valid, w_timeout_hit, w_dup;
  logic [2:0]         w_c;
  logic [FRAME_W-1:0] w_slot_buf;

  assign w_blank   = (w_col_s == '0);
  assign w_valid   = is_one_hot(w_col_s);
  assign w_illegal = !w_blank && !w_valid;
  assign w_c       = col_index(w_col_s);
  assign w_same    = w_valid && (w_c == r_idx);
  // Successor of the last latched column; after column 4 a fresh column 0 starts the next frame.
  assign w_adv     = w_valid && (r_state == COL_DONE) &&
                     (((r_idx != 3'd4) && (w_c == r_idx + 3'd1)) ||
                      ((r_idx == 3'd4) && (w_c == 3'd0)));
  assign w_err     = (r_state != SYNC_WAIT) && (w_illegal || (w_valid && !w_same && !w_adv));
  assign w_enter   = (w_valid && (w_c == 3'd0) && ((r_state == SYNC_WAIT) || w_err)) || w_adv;
  assign w_settled = (int'(r_settle) + 1 >= SETTLE_CYC);
  assign w_latch   = ((r_state == COL_SETTLE) && w_same && w_settled) || (w_enter && c_settle_imm);

  assign w_new_valid   = w_valid && (w_col_s != r_col_prev);
  assign w_timeout_hit = (r_to_cnt == c_to_last) && !w_new_valid;

  always_comb begin
    w_slot_buf = r_buf;
    for (int l = 0; l < N_LINE; l++) begin
      w_slot_buf[6'(bit_index(l, int'(w_c)))] = ~w_line_s[l];
    end
  end

`ifdef MATRIZ_RX_CHANGE_ONLY_EN
  logic r_delivered;
  assign w_dup = r_delivered && (r_buf == r_frame_out);
`else
  assign w_dup = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state       <= SYNC_WAIT;
      r_idx         <= '0;
      r_settle      <= '0;
      r_buf         <= '0;
      r_complete    <= 1'b0;
      r_col_prev    <= '0;
      r_to_cnt      <= '0;
      r_frame_out   <= '0;
      r_frame_valid <= 1'b0;
      r_scan_err    <= 1'b0;
      r_scan_lost   <= 1'b0;
      r_overrun     <= 1'b0;
`ifdef MATRIZ_RX_CHANGE_ONLY_EN
      r_delivered   <= 1'b0;
`endif
    end else begin
      r_scan_err <= 1'b0;
      r_complete <= 1'b0;
      r_col_prev <= w_col_s;

      if (w_new_valid)            r_to_cnt <= '0;
      else if (r_to_cnt != c_to_max) r_to_cnt <= r_to_cnt + 16'd1;

      if (w_timeout_hit) begin
        r_scan_lost <= 1'b1;
        r_state     <= SYNC_WAIT;
        r_buf       <= '0;
        r_settle    <= '0;
      end else begin
        if ((r_state == COL_SETTLE) && !w_err) begin
          if (w_same)       r_settle <= r_settle + 5'd1;
          else if (w_blank) r_settle <= '0;
        end
        if (w_err) begin
          r_scan_err <= 1'b1;
          r_buf      <= '0;
          r_state    <= SYNC_WAIT;
        end
        if (w_enter) begin
          r_state  <= COL_SETTLE;
          r_idx    <= w_c;
          r_settle <= 5'd1;
        end
        if (w_latch) begin
          r_buf      <= w_slot_buf;
          r_state    <= COL_DONE;
          r_idx      <= w_c;
          r_complete <= (w_c == 3'd4);
          if (w_c == 3'd0) r_scan_lost <= 1'b0;
        end
      end

      // A completion in the ack cycle replaces the frame rather than clearing valid.
      if (r_complete && !w_dup) begin
        if (!r_frame_valid || frame_ack) begin
          r_frame_out   <= r_buf;
          r_frame_valid <= 1'b1;
`ifdef MATRIZ_RX_CHANGE_ONLY_EN
          r_delivered   <= 1'b1;
`endif
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (frame_ack) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

  assign frame_out   = r_frame_out;
  assign frame_valid = r_frame_valid;
  assign scan_err    = r_scan_err;
  assign scan_lost   = r_scan_lost;
  assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_modulo_receptor_varredura_matriz.sv
`default_nettype none
// ============================================================================
// Module : tb_modulo_receptor_varredura_matriz
// Brief  : Directed self-checking bench for the matrix scan receiver.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_modulo_receptor_varredura_matriz;
  import modulo_receptor_varredura_matriz_pkg::*;

  typedef logic [4:0][6:0] lines_t;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [4:0]  m_col = '0;
  logic [6:0]  m_line = '1;
  logic        frame_ack = 1'b0;
  logic [34:0] frame_out;
  logic        frame_valid, scan_err, scan_lost, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int errs;

  always #5 clk = ~clk;

  modulo_receptor_varredura_matriz dut (
    .clk(clk), .clr(clr), .m_col(m_col), .m_line(m_line), .frame_ack(frame_ack),
    .frame_out(frame_out), .frame_valid(frame_valid), .scan_err(scan_err),
    .scan_lost(scan_lost), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [4:0] col_word(input int c);
    logic [4:0] w;
    w = 5'b10000;
    return w >> c;
  endfunction

  function automatic lines_t mk(input logic [6:0] l0, l1, l2, l3, l4);
    lines_t f;
    f[0] = l0; f[1] = l1; f[2] = l2; f[3] = l3; f[4] = l4;
    return f;
  endfunction

  task automatic scan_cols(input lines_t f, input int first, input int last);
    for (int c = first; c <= last; c++) begin
      m_col  = col_word(c);
      m_line = f[c];
      step(8);
      m_col  = '0;
      m_line = '1;
      step(2);
    end
  endtask

  task automatic hold_count(input int n, inout int cnt);
    repeat (n) begin
      step(1);
      if (scan_err) cnt++;
    end
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    step(1);
    frame_ack = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    step(2);
    clr = 1'b1;
    step(2);
  endtask

  lines_t fa, fb, fc, fd, fe, ff, fg, dark;

  initial begin
    dark = mk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    fa = mk(7'b0111110, 7'h7F, 7'h7F, 7'h7F, 7'h7F);      // bits 34, 4
    fb = mk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b1111110);      // bit 0
    fc = mk(7'h7F, 7'h7F, 7'b1110111, 7'h7F, 7'h7F);      // bit 17
    fd = mk(7'h7F, 7'b1111110, 7'h7F, 7'h7F, 7'h7F);      // bit 3
    fe = mk(7'h7F, 7'h7F, 7'h7F, 7'b0111111, 7'h7F);      // bit 31
    ff = mk(7'b1011111, 7'h7F, 7'h7F, 7'h7F, 7'h7F);      // bit 29
    fg = mk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b0111111);      // bit 30

    step(3);
    check("rst_valid",   64'(frame_valid), 64'd0);
    check("rst_out",     64'(frame_out),   64'd0);
    check("rst_err",     64'(scan_err),    64'd0);
    check("rst_lost",    64'(scan_lost),   64'd0);
    check("rst_overrun", 64'(overrun),     64'd0);
    clr = 1'b1;
    step(2);

    // clean frame with exact completion latency
    scan_cols(fa, 0, 3);
    m_col = col_word(4); m_line = fa[4];
    step(4);
    check("a_not_yet", 64'(frame_valid), 64'd0);
    step(1);
    check("a_valid",   64'(frame_valid), 64'd1);
    check("a_out",     64'(frame_out),   64'h4_0000_0010);
    step(3);
    m_col = '0; m_line = '1;
    step(2);
    check("a_no_err",  64'(scan_err),    64'd0);
    pulse_ack();
    check("a_ack_clr", 64'(frame_valid), 64'd0);

    // backpressure
    scan_cols(fb, 0, 4);
    check("b_valid", 64'(frame_valid), 64'd1);
    check("b_out",   64'(frame_out),   64'h1);
    check("b_no_ovr", 64'(overrun),    64'd0);
    scan_cols(fc, 0, 4);
    check("c_held_out",   64'(frame_out),   64'h1);
    check("c_held_valid", 64'(frame_valid), 64'd1);
    check("c_overrun",    64'(overrun),     64'd1);
    pulse_ack();
    check("c_ack_clr",    64'(frame_valid), 64'd0);
    check("c_ovr_sticky", 64'(overrun),     64'd1);
    do_reset();
    check("ovr_rst", 64'(overrun), 64'd0);

    // ack coincident with completion
    scan_cols(fd, 0, 4);
    check("d_out", 64'(frame_out), 64'h8);
    scan_cols(fe, 0, 3);
    m_col = col_word(4); m_line = fe[4];
    step(4);
    frame_ack = 1'b1;
    step(1);
    frame_ack = 1'b0;
    check("e_valid",  64'(frame_valid), 64'd1);
    check("e_out",    64'(frame_out),   64'h8000_0000);
    check("e_no_ovr", 64'(overrun),     64'd0);
    step(3);
    m_col = '0; m_line = '1;
    step(2);
    pulse_ack();

    // illegal pattern mid-frame
    scan_cols(dark, 0, 1);
    errs = 0;
    m_col = 5'b11000;
    hold_count(6, errs);
    m_col = '0;
    hold_count(2, errs);
    check("illegal_pulses", 64'(errs), 64'd1);
    scan_cols(dark, 2, 4);
    check("illegal_no_frame", 64'(frame_valid), 64'd0);

    // out-of-order 0,1,3
    scan_cols(dark, 0, 1);
    errs = 0;
    m_col = col_word(3);
    hold_count(8, errs);
    check("order_pulses", 64'(errs), 64'd1);
    check("order_state",  64'(dut.r_state), 64'(SYNC_WAIT));
    m_col = '0;
    step(2);
    scan_cols(dark, 4, 4);
    check("order_no_frame", 64'(frame_valid), 64'd0);

    // settle filter: one-cycle column then a two-cycle column
    m_col = col_word(0); m_line = 7'b0000000;
    step(1);
    m_col = '0; m_line = '1;
    step(5);
    check("glitch_no_sample", 64'(dut.r_state), 64'(COL_SETTLE));
    m_col = col_word(0); m_line = ff[0];
    step(2);
    m_col = '0; m_line = '1;
    step(4);
    check("settle_sample", 64'(dut.r_state), 64'(COL_DONE));
    scan_cols(ff, 1, 4);
    check("f_valid", 64'(frame_valid), 64'd1);
    check("f_out",   64'(frame_out),   64'h2000_0000);

    // timeout with a pending frame
    step(4200);
    check("to_lost",       64'(scan_lost),   64'd1);
    check("to_keep_valid", 64'(frame_valid), 64'd1);
    check("to_keep_out",   64'(frame_out),   64'h2000_0000);
    pulse_ack();
    scan_cols(fg, 0, 0);
    check("to_resume", 64'(scan_lost), 64'd0);
    scan_cols(fg, 1, 4);
    check("g_out", 64'(frame_out), 64'h4000_0000);
    scan_cols(fa, 0, 4);
    check("g_overrun", 64'(overrun), 64'd1);

    // asynchronous reset mid-frame
    scan_cols(fa, 0, 2);
    m_col = col_word(3);
    step(3);
    clr = 1'b0;
    #1;
    check("amid_valid",   64'(frame_valid), 64'd0);
    check("amid_out",     64'(frame_out),   64'd0);
    check("amid_overrun", 64'(overrun),     64'd0);
    check("amid_lost",    64'(scan_lost),   64'd0);
    m_col = '0;
    step(2);
    clr = 1'b1;
    step(2);
    check("amid_state", 64'(dut.r_state), 64'(SYNC_WAIT));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
